// File: rtl/seq_detector_1011.sv
// Overlapping Mealy detector for serial pattern 1011. A synchronized rising edge
// of step_clk advances the FSM by one bit of din, all in the clk_in domain.
module seq_detector_1011 #(
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             step_clk,
  input  logic             din,
  input  logic             clr,
  output logic [1:0]       state,
  output logic             detect_pulse,
  output logic             det_led,
  output logic [CNT_W-1:0] det_count
);

  typedef enum logic [1:0] {
    S0   = 2'd0,
    S1   = 2'd1,
    S10  = 2'd2,
    S101 = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    if (&value) begin
      return value;
    end else begin
      return value + CNT_W'(1);
    end
  endfunction

  logic             step_sync1_r;
  logic             step_sync2_r;
  logic             step_edge_r;
  logic             din_sync1_r;
  logic             din_s;
  logic             step_s;
  logic             hit_s;
  state_t           state_r;
  state_t           state_nxt_s;
  logic             pulse_r;
  logic             pulse_nxt_s;
  logic             led_r;
  logic             led_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;

  // Synchronizers; step chain resets high so a level present at reset release is not an edge.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      step_sync1_r <= 1'b1;
      step_sync2_r <= 1'b1;
      step_edge_r  <= 1'b1;
      din_sync1_r  <= 1'b0;
      din_s        <= 1'b0;
    end else begin
      step_sync1_r <= step_clk;
      step_sync2_r <= step_sync1_r;
      step_edge_r  <= step_sync2_r;
      din_sync1_r  <= din;
      din_s        <= din_sync1_r;
    end
  end

  assign step_s = step_sync2_r & ~step_edge_r;
  assign hit_s  = step_s && (state_r == S101) && din_s;

  // Next-state, flag and counter logic; clr overrides and swallows a coincident step.
  always_comb begin
    state_nxt_s = state_r;
    pulse_nxt_s = 1'b0;
    led_nxt_s   = led_r;
    count_nxt_s = count_r;
    if (clr) begin
      state_nxt_s = S0;
      led_nxt_s   = 1'b0;
      count_nxt_s = '0;
    end else if (step_s) begin
      pulse_nxt_s = hit_s;
      led_nxt_s   = hit_s;
      if (hit_s) begin
        count_nxt_s = sat_inc(count_r);
      end else begin
        count_nxt_s = count_r;
      end
      case (state_r)
        S0:      state_nxt_s = din_s ? S1 : S0;
        S1:      state_nxt_s = din_s ? S1 : S10;
        S10:     state_nxt_s = din_s ? S101 : S0;
        S101:    state_nxt_s = din_s ? S1 : S10;
        default: state_nxt_s = S0;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Output registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S0;
      pulse_r <= 1'b0;
      led_r   <= 1'b0;
      count_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      pulse_r <= pulse_nxt_s;
      led_r   <= led_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  assign state        = state_r;
  assign detect_pulse = pulse_r;
  assign det_led      = led_r;
  assign det_count    = count_r;

endmodule

// File: tb/tb_seq_detector_1011.sv
// Directed bench for seq_detector_1011; a second instance with CNT_W=2 shares the
// stimulus and exercises counter saturation.
module tb_seq_detector_1011;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       step_clk;
  logic       din;
  logic       clr;
  logic [1:0] state;
  logic       detect_pulse;
  logic       det_led;
  logic [7:0] det_count;
  logic [1:0] sat_state;
  logic       sat_pulse;
  logic       sat_led;
  logic [1:0] sat_count;

  int tests = 0;
  int fails = 0;

  seq_detector_1011 #(.CNT_W(8)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .step_clk(step_clk), .din(din), .clr(clr),
    .state(state), .detect_pulse(detect_pulse), .det_led(det_led), .det_count(det_count)
  );

  seq_detector_1011 #(.CNT_W(2)) dut_sat (
    .clk_in(clk_in), .rst_n(rst_n), .step_clk(step_clk), .din(din), .clr(clr),
    .state(sat_state), .detect_pulse(sat_pulse), .det_led(sat_led), .det_count(sat_count)
  );

  always #5 clk_in = ~clk_in;

  // One full step_clk period carrying bit b; reports detect_pulse cycles and the
  // post-rise edge index of the last one. clr_step asserts clr on the consuming edge.
  task automatic send_bit(input logic b, input logic clr_step, output int pulses, output int pos);
    pulses = 0;
    pos = 0;
    din = b;
    repeat (3) begin
      @(posedge clk_in); #1;
      if (detect_pulse) pulses++;
    end
    step_clk = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk_in); #1;
      if (k == 2) clr = clr_step;
      if (k == 3) clr = 1'b0;
      if (k == 4) step_clk = 1'b0;
      if (detect_pulse) begin
        pulses++;
        pos = k;
      end
    end
  endtask

  task automatic do_clear();
    @(posedge clk_in); #1;
    clr = 1'b1;
    @(posedge clk_in); #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    int pulses;
    rst_n = 1'b0;
    step_clk = 1'b1;
    din = 1'b0;
    clr = 1'b0;
    repeat (3) @(posedge clk_in);
    #1 rst_n = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(posedge clk_in); #1;
      if (detect_pulse || sat_pulse) pulses++;
    end
    tests++;
    if (state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state); end
    tests++;
    if (pulses !== 0) begin fails++; $display("FAIL reset_pulse: got %0d pulses want 0", pulses); end
    tests++;
    if (det_count !== 8'd0 || det_led !== 1'b0) begin
      fails++; $display("FAIL reset_count: got count %0d led %b want 0 0", det_count, det_led);
    end
    step_clk = 1'b0;
    repeat (4) @(posedge clk_in);
    #1;
    tests++;
    if (state !== 2'd0) begin fails++; $display("FAIL reset_fall: got state %0d want 0", state); end
  endtask

  task automatic test_basic();
    logic [3:0] bits  = 4'b1101;
    logic [1:0] exp_s [4] = '{2'd1, 2'd2, 2'd3, 2'd1};
    int pulses, pos;
    for (int i = 0; i < 4; i++) begin
      send_bit(bits[i], 1'b0, pulses, pos);
      tests++;
      if (state !== exp_s[i]) begin fails++; $display("FAIL basic_state bit%0d: got %0d want %0d", i + 1, state, exp_s[i]); end
      tests++;
      if (pulses !== (i == 3 ? 1 : 0)) begin fails++; $display("FAIL basic_pulses bit%0d: got %0d", i + 1, pulses); end
    end
    tests++;
    if (pos !== 3) begin fails++; $display("FAIL basic_latency: pulse at edge %0d want 3", pos); end
    tests++;
    if (det_count !== 8'd1 || det_led !== 1'b1) begin
      fails++; $display("FAIL basic_flags: got count %0d led %b want 1 1", det_count, det_led);
    end
    send_bit(1'b0, 1'b0, pulses, pos);
    tests++;
    if (det_led !== 1'b0 || state !== 2'd2 || pulses !== 0) begin
      fails++; $display("FAIL basic_led_drop: got led %b state %0d pulses %0d want 0 2 0", det_led, state, pulses);
    end
  endtask

  task automatic test_overlap();
    logic [9:0] bits = 10'b1101101101;
    int pulses, pos, hits;
    do_clear();
    tests++;
    if (state !== 2'd0 || det_count !== 8'd0) begin
      fails++; $display("FAIL clear_only: got state %0d count %0d want 0 0", state, det_count);
    end
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      send_bit(bits[i], 1'b0, pulses, pos);
      hits += pulses;
      tests++;
      if (pulses !== ((i == 3 || i == 6 || i == 9) ? 1 : 0)) begin
        fails++; $display("FAIL overlap_pulse bit%0d: got %0d", i + 1, pulses);
      end
    end
    tests++;
    if (det_count !== 8'd3 || state !== 2'd1 || hits !== 3) begin
      fails++; $display("FAIL overlap_total: got count %0d state %0d hits %0d want 3 1 3", det_count, state, hits);
    end
  endtask

  task automatic test_near_miss();
    logic [9:0] bits = 10'b1101010011;
    logic [1:0] exp_s [10] = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd1};
    int pulses, pos;
    do_clear();
    for (int i = 0; i < 10; i++) begin
      send_bit(bits[i], 1'b0, pulses, pos);
      tests++;
      if (state !== exp_s[i] || pulses !== (i == 9 ? 1 : 0)) begin
        fails++; $display("FAIL near_miss bit%0d: got state %0d pulses %0d want %0d", i + 1, state, pulses, exp_s[i]);
      end
    end
    tests++;
    if (det_count !== 8'd1) begin fails++; $display("FAIL near_miss_count: got %0d want 1", det_count); end
  endtask

  task automatic test_saturation_clear();
    logic [15:0] bits = 16'b1101101101101101;
    int pulses, pos, hits;
    do_clear();
    hits = 0;
    for (int i = 0; i < 16; i++) begin
      send_bit(bits[i], 1'b0, pulses, pos);
      if (pulses == 1) begin
        hits++;
        tests++;
        if (sat_count !== ((hits > 3) ? 2'd3 : 2'(hits))) begin
          fails++; $display("FAIL sat_count hit%0d: got %0d want %0d", hits, sat_count, (hits > 3) ? 3 : hits);
        end
      end
    end
    tests++;
    if (hits !== 5 || det_count !== 8'd5 || sat_state !== 2'd1) begin
      fails++; $display("FAIL sat_total: got hits %0d count %0d sat_state %0d want 5 5 1", hits, det_count, sat_state);
    end
    send_bit(1'b0, 1'b1, pulses, pos);
    tests++;
    if (state !== 2'd0 || det_count !== 8'd0 || sat_count !== 2'd0 || det_led !== 1'b0) begin
      fails++; $display("FAIL clr_step: got state %0d count %0d sat %0d led %b want 0 0 0 0", state, det_count, sat_count, det_led);
    end
    send_bit(1'b1, 1'b0, pulses, pos);
    tests++;
    if (state !== 2'd1 || pulses !== 0) begin
      fails++; $display("FAIL clr_after: got state %0d pulses %0d want 1 0", state, pulses);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] bits = 3'b101;
    int pulses, pos;
    do_clear();
    for (int i = 0; i < 3; i++) send_bit(bits[i], 1'b0, pulses, pos);
    tests++;
    if (state !== 2'd3) begin fails++; $display("FAIL mid_pre: got state %0d want 3", state); end
    @(posedge clk_in); #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if (state !== 2'd0 || det_count !== 8'd0 || det_led !== 1'b0 || detect_pulse !== 1'b0) begin
      fails++; $display("FAIL mid_async: got state %0d count %0d want 0 0", state, det_count);
    end
    @(posedge clk_in); #1;
    rst_n = 1'b1;
    send_bit(1'b1, 1'b0, pulses, pos);
    tests++;
    if (state !== 2'd1 || pulses !== 0 || det_count !== 8'd0) begin
      fails++; $display("FAIL mid_after: got state %0d pulses %0d count %0d want 1 0 0", state, pulses, det_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_near_miss();
    test_saturation_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_detector_1011.md
# seq_detector_1011

Overlapping Mealy-FSM detector for the serial pattern 1011, directly downstream of the clock divider. It runs entirely on the fast board clock and treats the divider's slow square-wave output as a step strobe: each rising edge of that output consumes one serial input bit. It produces a one-cycle detect pulse, an LED-friendly held flag, a saturating hit counter and the FSM state for debug LEDs.

## Interface
- CNT_W, 8, width of the saturating detection counter
- clk_in  input  1  fast system clock; the only clock in the block
- rst_n  input  1  reset, asynchronous and active-low
- step_clk  input  1  slow square wave from the clock divider; treated as asynchronous data and synchronized, never used as a clock
- din  input  1  serial data bit from a switch; asynchronous, synchronized internally
- clr  input  1  synchronous clear of the FSM, flags and counter (clk_in domain)
- state  output  2  FSM state: S0=0, S1=1, S10=2, S101=3
- detect_pulse  output  1  high for exactly one clk_in cycle per detection
- det_led  output  1  high from a detection until the next step
- det_count  output  CNT_W  number of detections, saturating at all-ones

## Operation
- Synchronizers: step_clk passes through a 2-FF synchronizer and then a third edge register. All three reset to 1, so a step_clk that is low or high at reset release never produces a spurious step.
- din passes through a 2-FF synchronizer reset to 0 (din_s).
- step = (sync2 == 1) && (edge_reg == 0), combinational. Only rising edges of step_clk count.
- FSM transitions occur only on clk_in edges where step == 1. The value consumed is din_s in that cycle.
  - S0: bit 1 → S1; bit 0 → S0.
  - S1: 1 → S1; 0 → S10.
  - S10: 1 → S101; 0 → S0.
  - S101: 1 → S1 with hit (overlap: the trailing 1 is a valid prefix); 0 → S10 (overlap: the trailing 10 is kept).
- hit = step && state == S101 && din_s. This is the Mealy condition.
- On a hit edge:
  - detect_pulse ← 1.
  - det_led ← 1.
  - det_count increments unless it already holds all-ones, in which case it holds.
- On a non-hit step edge: detect_pulse ← 0 and det_led ← 0.
- Between steps: detect_pulse ← 0 and det_led holds.
- clr: synchronous and highest priority. When clr == 1:
  - state ← S0, detect_pulse ← 0, det_led ← 0, det_count ← 0.
  - A coincident step is discarded; it consumes no bit.
  - The synchronizers are not cleared.
- Reset values: state = S0, detect_pulse = 0, det_led = 0, det_count = 0.
- Asserting rst_n mid-sequence returns every output to its reset value immediately. The partial pattern is lost.

## Timing
- Step latency: step_clk rising is captured at clk_in edge 1. step is asserted in the cycle after edge 2. state, detect_pulse, det_led and det_count update at edge 3. Outputs are therefore valid 3 clk_in edges after the step_clk rise.
- din setup/hold: din must be stable from at least 3 clk_in cycles before the step_clk rise until at least 1 cycle after it.
- detect_pulse is registered, coincides with the new state (S1), and lasts exactly 1 clk_in cycle regardless of the step period.
- Throughput: one bit per step_clk period. step_clk high and low phases must each be at least 2 clk_in cycles, otherwise edges may be missed.
- No combinational path from any input to any output.

## Test plan
- Reset and idle: step_clk held high through rst_n release, din = 0, 20 clk_in cycles → state = 0, no detect_pulse, det_count = 0.
- Basic detection: bits 1,0,1,1 on 4 steps → state sequence 1,2,3,1. detect_pulse is high for 1 cycle, 3 clk_in edges after the 4th step_clk rise. det_count = 1 and det_led = 1 until the next step.
- Overlap: bits 1,0,1,1,0,1,1,0,1,1 → 3 detections (after bits 4, 7 and 10). det_count = 3, final state = 1.
- Non-matches and near-misses: bits 1,1,0,0,1,0,1,0,1,1 → exactly one detection, at bit 10. State after bit 4 = 0.
- Saturation and clear: CNT_W = 2 with 5 detections → det_count stays at 3 after the 3rd detection. Then assert clr coincident with a step → det_count = 0, state = 0, and that step's bit is not consumed.
- Reset mid-pattern: bits 1,0,1, then pulse rst_n low, then bit 1 → no detection, state = 1.
